// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and constants for the program loader.
// Contents: state_e FSM states, SYNC_BYTE_DEF frame marker, LEN_ZERO_COUNT (LEN=0 means 256 bytes).
package prog_loader_pkg;
   typedef enum logic [2:0] {IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, DONE} state_e;
   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
   localparam logic [8:0] LEN_ZERO_COUNT = 9'd256;
endpackage

// File: rtl/prog_loader_timer.sv
// prog_loader_timer: inter-byte idle timeout counter for the program loader.
// Ports: clk, rst (sync, active-high); clr restarts the count; run enables counting
// (count is held at zero while run is low); expired is high once TIMEOUT_CYCLES idle cycles have elapsed.
module prog_loader_timer #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expired
);
   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] cnt_q, cnt_d;
   assign expired = run && (cnt_q == LIMIT);
   always_comb cnt_d = (clr || !run) ? '0 : (expired ? cnt_q : cnt_q + 16'd1);
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: parses SYNC,ADDR,LEN,D[N],CHK frames from a byte stream into the 256x8 program memory.
// Ports: CLK, RESET (sync, active-high); RX_DATA/RX_VALID/RX_READY byte input handshake;
// MEM_WE/MEM_ADDR/MEM_DATA memory write port (1 cycle after each accepted data byte);
// CPU_HOLD keeps the MCU in reset while loading; LOAD_DONE pulses on a good frame; LOAD_ERR is sticky.
// Optional: define PROG_LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES idle cycles.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int              ADDR_WIDTH     = 8,
   parameter logic [7:0]      SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int              TIMEOUT_CYCLES = 50000
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            RX_DATA,
   input  logic                  RX_VALID,
   output logic                  RX_READY,
   output logic                  MEM_WE,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [7:0]            MEM_DATA,
   output logic                  CPU_HOLD,
   output logic                  LOAD_DONE,
   output logic                  LOAD_ERR
);
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [7:0]            sum_q, sum_d, data_q, data_d, sum_add;
   logic                  we_q, we_d, hold_q, hold_d, err_q, err_d;
   logic                  done_q, done_d, rdy_q, rdy_d;
   logic                  acc, timeout;

   assign acc     = RX_VALID && rdy_q;
   assign sum_add = sum_q + RX_DATA;

`ifdef PROG_LOADER_TIMEOUT_EN
   prog_loader_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (CLK),
      .rst     (RESET),
      .clr     (acc),
      .run     (state_q inside {S_ADDR, S_LEN, S_DATA, S_CHK}),
      .expired (timeout)
   );
`else
   // Constant false: waits indefinitely for the next byte.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      hold_d  = hold_q;
      err_d   = err_q;
      if (state_q == DONE) state_d = IDLE;
      else if (acc) begin
         case (state_q)
            IDLE: if (RX_DATA == SYNC_BYTE) begin
               state_d = S_ADDR;
               hold_d  = 1'b1;
               err_d   = 1'b0;
               sum_d   = '0;
            end
            S_ADDR: begin
               ptr_d   = RX_DATA[ADDR_WIDTH-1:0];
               sum_d   = sum_add;
               state_d = S_LEN;
            end
            S_LEN: begin
               cnt_d   = (RX_DATA == 8'd0) ? LEN_ZERO_COUNT : {1'b0, RX_DATA};
               sum_d   = sum_add;
               state_d = S_DATA;
            end
            S_DATA: begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               data_d  = RX_DATA;
               ptr_d   = ptr_q + 1'b1;
               cnt_d   = cnt_q - 9'd1;
               sum_d   = sum_add;
               state_d = (cnt_q == 9'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
               sum_d   = sum_add;
               state_d = (sum_add == 8'd0) ? DONE : IDLE;
               err_d   = (sum_add != 8'd0);
               hold_d  = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end else if (timeout) begin
         err_d   = 1'b1;
         hold_d  = 1'b0;
         state_d = IDLE;
      end
      // DONE is only entered from S_CHK, so this yields a single-cycle pulse.
      done_d = (state_d == DONE);
      rdy_d  = (state_d != DONE);
   end

   always_ff @(posedge CLK)
      if (RESET) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         hold_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
      end

   assign RX_READY  = rdy_q;
   assign MEM_WE    = we_q;
   assign MEM_ADDR  = addr_q;
   assign MEM_DATA  = data_q;
   assign CPU_HOLD  = hold_q;
   assign LOAD_DONE = done_q;
   assign LOAD_ERR  = err_q;
endmodule
